dct_transpose_8x8: RTL and testbench

DCT_TRANSPOSE_8X8 -- requirements
Module: dct_transpose_8x8

---
 rtl/dct_transpose_8x8.sv | 171 +++++++++++++++++
 tb/tb_dct_transpose_8x8.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_8x8.sv
// ---------------------------------------------------------------------------
// dct_transpose_8x8
//
// Ping-pong transpose buffer between the row and column passes of an 8x8
// 2D DCT. Row coefficients are written row-major (column position given by
// in_index, any order within a row); once a bank holds 64 beats it is read
// back column-major and handed to the next 1D stage.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous reset, active low
//   in_data     row coefficient from upstream stage
//   in_valid    qualifies in_data / in_index
//   in_index    column position of in_data within the current row
//   in_ready    write bank can accept a beat
//   out_data    transposed coefficient
//   out_valid   qualifies out_data / out_index / out_col
//   out_index   row number of out_data
//   out_col     column currently being emitted
//   out_ready   downstream accepts the beat
//   block_done  high in the cycle the last beat of a block is accepted
// ---------------------------------------------------------------------------
module dct_transpose_8x8 #(
    parameter int DATA_W = 18,
    parameter int N      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [2:0]        in_index,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [2:0]        out_index,
    output logic [2:0]        out_col,
    input  logic              out_ready,
    output logic              block_done
);

    localparam int DEPTH = 2 * N * N;

    // Two banks of 64 words, addressed {bank, row, col}.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [1:0]        full_q,      full_d;
    logic              wr_bank_q,   wr_bank_d;
    logic              rd_bank_q,   rd_bank_d;
    logic [2:0]        wr_row_q,    wr_row_d;
    logic [2:0]        wr_cnt_q,    wr_cnt_d;
    // Load side: bank and {col,row} pointer of the next word to move into
    // the output register. It runs one beat ahead of rd_bank so the first
    // word of the next block can be loaded while the last word of the
    // current block is being accepted.
    logic              ld_bank_q,   ld_bank_d;
    logic [5:0]        ld_ptr_q,    ld_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [2:0]        out_index_q, out_index_d;
    logic [2:0]        out_col_q,   out_col_d;

    logic              in_fire;
    logic              out_fire;
    logic              out_last;
    logic              wr_last;
    logic              ld_en;
    logic [6:0]        mem_waddr;
    logic [6:0]        mem_raddr;

    always_comb begin
        in_ready   = !full_q[wr_bank_q];
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid_q && out_ready;
        out_last   = out_fire && (out_col_q == 3'd7) && (out_index_q == 3'd7);
        block_done = out_last;
        wr_last    = in_fire && (wr_row_q == 3'd7) && (wr_cnt_q == 3'd7);
        // Output register is free when empty or being accepted this cycle.
        ld_en      = full_q[ld_bank_q] && (!out_valid_q || out_ready);
        mem_waddr  = {wr_bank_q, wr_row_q, in_index};
        mem_raddr  = {ld_bank_q, ld_ptr_q[2:0], ld_ptr_q[5:3]};
    end

    always_comb begin
        // The bank being filled is never full and the bank being drained
        // always is, so set and clear never target the same flag.
        full_d = full_q;
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (out_last) begin
            full_d[rd_bank_q] = 1'b0;
        end

        wr_bank_d = wr_bank_q ^ wr_last;
        rd_bank_d = rd_bank_q ^ out_last;

        // 3-bit wrap clears the beat count after beat 8 and the row after
        // row 8, which is exactly the end-of-block clear.
        wr_cnt_d = wr_cnt_q;
        wr_row_d = wr_row_q;
        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd7) begin
                wr_row_d = wr_row_q + 3'd1;
            end
        end

        ld_ptr_d  = ld_ptr_q;
        ld_bank_d = ld_bank_q;
        if (ld_en) begin
            ld_ptr_d = ld_ptr_q + 6'd1;
            if (ld_ptr_q == 6'd63) begin
                ld_bank_d = !ld_bank_q;
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_col_d   = out_col_q;
        if (ld_en) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[mem_raddr];
            out_index_d = ld_ptr_q[2:0];
            out_col_d   = ld_ptr_q[5:3];
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Bank storage is not reset; a discarded block is simply overwritten.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[mem_waddr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_row_q    <= 3'd0;
            wr_cnt_q    <= 3'd0;
            ld_bank_q   <= 1'b0;
            ld_ptr_q    <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= 3'd0;
            out_col_q   <= 3'd0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_row_q    <= wr_row_d;
            wr_cnt_q    <= wr_cnt_d;
            ld_bank_q   <= ld_bank_d;
            ld_ptr_q    <= ld_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_col_q   <= out_col_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_dct_transpose_8x8.sv
module tb_dct_transpose_8x8;

    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [2:0]    in_index = 3'd0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [2:0]    out_index;
    logic [2:0]    out_col;
    logic          out_ready = 1'b0;
    logic          block_done;

    always #5 clk = ~clk;

    dct_transpose_8x8 #(.DATA_W(DW), .N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_index   (in_index),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_col    (out_col),
        .out_ready  (out_ready),
        .block_done (block_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        int            col;
        bit            last;
    } exp_t;

    exp_t exp_q[$];
    int   done_at[$];

    int checks = 0;
    int errors = 0;

    // Reference model: an 8x8 matrix filled by row, emitted by column.
    logic [DW-1:0] m_blk [8][8];
    int m_cnt = 0;
    int m_row = 0;
    int acc_cnt = 0;

    int fire_cnt = 0;
    int run = 0;
    int max_run = 0;

    bit            hold = 0;
    logic [DW-1:0] h_data;
    logic [2:0]    h_idx;
    logic [2:0]    h_col;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic [2:0] idx);
        exp_t e;
        acc_cnt++;
        m_blk[m_row][idx] = d;
        m_cnt++;
        if (m_cnt == 8) begin
            m_cnt = 0;
            m_row++;
            if (m_row == 8) begin
                m_row = 0;
                for (int c = 0; c < 8; c++) begin
                    for (int r = 0; r < 8; r++) begin
                        e.data = m_blk[r][c];
                        e.row  = r;
                        e.col  = c;
                        e.last = (r == 7) && (c == 7);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [2:0] idx);
        bit done = 0;
        in_data  = d;
        in_index = idx;
        in_valid = 1'b1;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, idx);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    // mode 0: data 8r+c in index order; mode 1: random data, shuffled
    // indices; mode 2: row 0 reversed with data = index, rest random.
    task automatic send_block(input int mode);
        int perm[8];
        int j, tmp;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            if (mode == 1) begin
                for (int i = 7; i > 0; i--) begin
                    j = $urandom_range(i, 0);
                    tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
                end
            end
            for (int c = 0; c < 8; c++) begin
                if (mode == 0)
                    send(DW'(8 * r + c), 3'(c));
                else if (mode == 2 && r == 0)
                    send(DW'(7 - c), 3'(7 - c));
                else
                    send(DW'($urandom), 3'(perm[c]));
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("drain_idle_valid", out_valid, 0);
    endtask

    task automatic new_test();
        fire_cnt = 0;
        done_at.delete();
        max_run = 0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        bit fire;
        if (!rst) begin
            hold = 0;
            run  = 0;
        end else begin
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, h_data);
                check("hold_index", out_index, h_idx);
                check("hold_col", out_col, h_col);
            end
            fire = out_valid && out_ready;
            if (fire) begin
                fire_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=data %0d row %0d col %0d required=no output at %0t",
                             out_data, out_index, out_col, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_index", out_index, e.row);
                    check("out_col", out_col, e.col);
                    check("block_done", block_done, e.last);
                end
                if (block_done) done_at.push_back(fire_cnt);
            end else begin
                check("block_done_idle", block_done, 0);
            end
            hold   = out_valid && !out_ready;
            h_data = out_data;
            h_idx  = out_index;
            h_col  = out_col;
            run    = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
    end

    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int base;
        int t;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_col", out_col, 0);
        check("rst_block_done", block_done, 0);
        check("rst_in_ready", in_ready, 1);

        // Single block in order, plus output latency
        new_test();
        out_ready = 1'b1;
        send_block(0);
        in_valid = 1'b0;
        check("lat_pre_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_rise_valid", out_valid, 1);
        check("lat_first_data", out_data, 0);
        drain();
        check("single_beats", fire_cnt, 64);
        check("single_done_cnt", done_at.size(), 1);
        if (done_at.size() > 0) check("single_done_pos", done_at[0], 64);

        // Permuted indices in row 0
        new_test();
        send_block(2);
        in_valid = 1'b0;
        drain();
        check("perm_beats", fire_cnt, 64);

        // Backpressure 1,0,0,1
        new_test();
        fork
            begin
                send_block(1);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 3000 && fire_cnt < 64; k++) begin
                    out_ready = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_beats", fire_cnt, 64);
        check("bp_done_cnt", done_at.size(), 1);

        // Overflow: three blocks with out_ready low
        new_test();
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int b = 0; b < 3; b++) send_block(1);
                in_valid = 1'b0;
            end
            begin
                t = 0;
                while (acc_cnt < base + 128 && t < 3000) begin
                    @(posedge clk);
                    t++;
                end
                #1;
                check("ovf_in_ready_fall", in_ready, 0);
                repeat (8) @(posedge clk);
                #1;
                check("ovf_in_ready_stall", in_ready, 0);
                check("ovf_no_accept", acc_cnt, base + 128);
                check("ovf_hold_valid", out_valid, 1);
                out_ready = 1'b1;
                t = 0;
                while (t < 3000) begin
                    @(negedge clk);
                    if (block_done) break;
                    t++;
                end
                check("ovf_first_done_seen", block_done, 1);
                @(posedge clk);
                #1;
                check("ovf_in_ready_rise", in_ready, 1);
            end
        join
        drain();
        check("ovf_beats", fire_cnt, 192);
        check("ovf_done_cnt", done_at.size(), 3);

        // Back-to-back blocks with no bubble
        new_test();
        out_ready = 1'b1;
        send_block(1);
        send_block(1);
        in_valid = 1'b0;
        drain();
        check("b2b_run", max_run, 128);
        check("b2b_done_cnt", done_at.size(), 2);
        if (done_at.size() == 2) begin
            check("b2b_done_first", done_at[0], 64);
            check("b2b_done_second", done_at[1], 128);
        end

        // Reset after 30 beats of a block
        new_test();
        for (int i = 0; i < 30; i++) send(DW'($urandom), 3'(i % 8));
        in_valid = 1'b0;
        rst = 1'b0;
        m_cnt = 0;
        m_row = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        new_test();
        send_block(1);
        in_valid = 1'b0;
        drain();
        check("mid_rst_beats", fire_cnt, 64);
        check("mid_rst_done_cnt", done_at.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
